dmem_responder: RTL and testbench

//  Data-memory responder: the memory side of the core's DMem interface (addr, r/w

---
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the core's DMem handshake, with wait states and error reporting
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_r_enable,
    input  logic              mem_w_enable,
    input  logic [1:0]        mem_w_size,
    input  logic [DATA_W-1:0] mem_w_data,
    output logic [DATA_W-1:0] mem_r_data,
    output logic              mem_ready,
    output logic              mem_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              bad;
    logic              err;
    logic [DATA_W-1:0] ram [DEPTH_WORDS];

    logic              req;
    logic              req_bad;
    logic              req_err;
    logic [3:0]        req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              to_resp;
    logic              cur_bad;
    logic              cur_err;
    logic [IDX_W-1:0]  rd_idx;

    // Decode the live request and pick live vs latched attributes for the cycle that enters RESP
    always_comb begin
        req       = mem_r_enable | mem_w_enable;
        req_bad   = (|mem_addr[ADDR_W-1:IDX_W+2])
                  | (mem_w_enable & ((mem_w_size == 2'b01 & mem_addr[0])
                                   | (mem_w_size == 2'b10 & |mem_addr[1:0])
                                   | (mem_w_size == 2'b11)));
        req_err   = req_bad | (mem_r_enable & mem_w_enable);
        req_be    = mem_w_size == 2'b00 ? 4'b0001 << mem_addr[1:0]
                  : mem_w_size == 2'b01 ? 4'b0011 << mem_addr[1:0] : 4'b1111;
        req_wdata = mem_w_size == 2'b00 ? {4{mem_w_data[7:0]}}
                  : mem_w_size == 2'b01 ? {2{mem_w_data[15:0]}} : mem_w_data;
        to_resp   = state == IDLE ? req && LATENCY == 1 : state == WAIT && cnt == 4'd1;
        cur_bad   = state == IDLE ? req_bad : bad;
        cur_err   = state == IDLE ? req_err : err;
        rd_idx    = state == IDLE ? mem_addr[IDX_W+1:2] : idx;
    end

    // Handshake FSM: accept in IDLE, count wait states, pulse ready with the registered read word
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_r_data <= '0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            mem_ready <= to_resp;
            mem_err   <= to_resp & cur_err;
            if (to_resp)
                mem_r_data <= cur_bad ? '0 : ram[rd_idx];
            case (state)
                IDLE: if (req) begin
                    idx   <= mem_addr[IDX_W+1:2];
                    be    <= req_be;
                    wdata <= req_wdata;
                    wr    <= mem_w_enable & ~req_bad;
                    bad   <= req_bad;
                    err   <= req_err;
                    cnt   <= 4'(LATENCY - 1);
                    state <= LATENCY == 1 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit the write at the edge that ends RESP, after the pre-write word has been returned
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && wr)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of three responders (LATENCY 1, 4, 2) sharing address/data buses
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [1:0]  size = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  ren = '0;
    logic [2:0]  wen = '0;
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [31:0] rdata [3];
    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          n;
    int          last;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(1)) u0 (.clk(clk), .reset(reset), .mem_addr(addr), .mem_r_enable(ren[0]),
        .mem_w_enable(wen[0]), .mem_w_size(size), .mem_w_data(wdata), .mem_r_data(rdata[0]),
        .mem_ready(rdy[0]), .mem_err(err[0]));
    dmem_responder #(.LATENCY(4)) u1 (.clk(clk), .reset(reset), .mem_addr(addr), .mem_r_enable(ren[1]),
        .mem_w_enable(wen[1]), .mem_w_size(size), .mem_w_data(wdata), .mem_r_data(rdata[1]),
        .mem_ready(rdy[1]), .mem_err(err[1]));
    dmem_responder #(.LATENCY(2)) u2 (.clk(clk), .reset(reset), .mem_addr(addr), .mem_r_enable(ren[2]),
        .mem_w_enable(wen[2]), .mem_w_size(size), .mem_w_data(wdata), .mem_r_data(rdata[2]),
        .mem_ready(rdy[2]), .mem_err(err[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request on responder d; a2 replaces the address right after the accept edge
    task automatic xact(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] a2,
                        input logic [1:0] s, input logic [31:0] wd, output int l);
        addr = a;
        size = s;
        wdata = wd;
        ren[d] = r;
        wen[d] = w;
        l = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) addr = a2;
            if (rdy[d]) begin
                l = k;
                break;
            end
        end
        ren[d] = 1'b0;
        wen[d] = 1'b0;
    endtask

    task automatic op(input string tag, input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic [31:0] wd, input int elat, input logic eerr,
                      input logic chkd, input logic [31:0] edata);
        int l;
        xact(d, r, w, a, a, s, wd, l);
        chk({tag, ".lat"}, l, elat);
        chk({tag, ".err"}, err[d], eerr);
        if (chkd) chk({tag, ".data"}, rdata[d], edata);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, {rdy[d], err[d]}, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", rdy, 0);
        chk("rst.err", err, 0);
        for (int i = 0; i < 3; i++) chk("rst.rdata", rdata[i], 0);
        reset = 1'b0;

        op("t1.wr", 0, 0, 1, 32'h10, 2'b10, 32'hDEADBEEF, 1, 0, 0, 0);
        op("t1.rd", 0, 1, 0, 32'h10, 2'b00, 0, 1, 0, 1, 32'hDEADBEEF);

        op("t2.wb", 0, 0, 1, 32'h13, 2'b00, 32'h000000AA, 1, 0, 1, 32'hDEADBEEF);
        op("t2.rb", 0, 1, 0, 32'h10, 2'b00, 0, 1, 0, 1, 32'hAAADBEEF);
        op("t2.wh", 0, 0, 1, 32'h12, 2'b01, 32'h00001234, 1, 0, 1, 32'hAAADBEEF);
        op("t2.rh", 0, 1, 0, 32'h10, 2'b00, 0, 1, 0, 1, 32'h1234BEEF);

        op("t4.w0", 0, 0, 1, 32'h00, 2'b10, 32'h01020304, 1, 0, 0, 0);
        op("t4.wmis", 0, 0, 1, 32'h11, 2'b10, 32'hFFFFFFFF, 1, 1, 1, 0);
        op("t4.hmis", 0, 0, 1, 32'h01, 2'b01, 32'h0000FFFF, 1, 1, 1, 0);
        op("t4.s11", 0, 0, 1, 32'h10, 2'b11, 32'hFFFFFFFF, 1, 1, 1, 0);
        op("t4.r10", 0, 1, 0, 32'h10, 2'b00, 0, 1, 0, 1, 32'h1234BEEF);
        op("t4.r00", 0, 1, 0, 32'h00, 2'b00, 0, 1, 0, 1, 32'h01020304);
        op("t4.range", 0, 1, 0, 32'h1000, 2'b00, 0, 1, 1, 1, 0);
        op("t4.rw", 0, 1, 1, 32'h04, 2'b10, 32'h55667788, 1, 1, 0, 0);
        op("t4.r04", 0, 1, 0, 32'h04, 2'b00, 0, 1, 0, 1, 32'h55667788);

        op("t3.w20", 1, 0, 1, 32'h20, 2'b10, 32'hCAFEF00D, 4, 0, 0, 0);
        op("t3.w24", 1, 0, 1, 32'h24, 2'b10, 32'h11111111, 4, 0, 0, 0);
        xact(1, 1, 0, 32'h20, 32'h24, 2'b00, 0, lat);
        chk("t3.lat", lat, 4);
        chk("t3.data", rdata[1], 32'hCAFEF00D);
        chk("t3.err", err[1], 0);
        @(posedge clk);
        #1;
        chk("t3.pulse", rdy[1], 0);

        addr = 32'h20;
        size = 2'b10;
        wdata = 32'h99999999;
        wen[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.acc", rdy[1], 0);
        @(posedge clk);
        #1;
        chk("t5.wait", rdy[1], 0);
        reset = 1'b1;
        wen[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("t5.rst", rdy[1], 0);
        chk("t5.rdata", rdata[1], 0);
        reset = 1'b0;
        op("t5.rd", 1, 1, 0, 32'h20, 2'b00, 0, 4, 0, 1, 32'hCAFEF00D);

        for (int i = 0; i < 8; i++)
            op("t6.wr", 2, 0, 1, 32'h40 + 4 * i, 2'b10, 32'hA0000000 + i * 32'h01010101, 2, 0, 0, 0);
        n = 0;
        last = 0;
        addr = 32'h40;
        ren[2] = 1'b1;
        for (int k = 1; k <= 40 && n < 8; k++) begin
            @(posedge clk);
            #1;
            if (rdy[2]) begin
                chk("t6.data", rdata[2], 32'hA0000000 + n * 32'h01010101);
                chk("t6.gap", k - last, n == 0 ? 2 : 3);
                last = k;
                n++;
                addr = 32'h40 + 4 * n;
                if (n == 8) ren[2] = 1'b0;
            end
        end
        ren[2] = 1'b0;
        chk("t6.count", n, 8);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t6.idle", rdy[2], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
